// File: rtl/instr_pkg.sv
// Shared encoding constants for the program-load path: opcodes (also used by
// the core decoder), request kinds, immediate range limits and encoder states.
package instr_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_CLZ    = 7'b0111011;

  typedef enum logic [2:0] {
    K_R      = 3'd0,
    K_I      = 3'd1,
    K_LOAD   = 3'd2,
    K_STORE  = 3'd3,
    K_BRANCH = 3'd4,
    K_JAL    = 3'd5,
    K_JALR   = 3'd6,
    K_CLZ    = 3'd7
  } kind_e;

  // Inclusive signed limits of each immediate format (byte offsets for B/J).
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_PEND  = 1'b1
  } enc_state_e;

  // True when the 32-bit two's-complement immediate lies within [lo, hi].
  function automatic logic imm_in_range(logic [31:0] imm, int lo, int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational field packer: turns one request into an RV32I word and flags
// whether its immediate fits the chosen format.
module imm_packer
  import instr_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Pick the format by kind; R/CLZ ignore the immediate and are always legal.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (kind_e'(kind))
      K_R: begin
        word  = {funct7, rs2, rs1, funct3, rd, OP_R};
        legal = 1'b1;
      end
      K_I: begin
        word  = {imm[11:0], rs1, funct3, rd, OP_I};
        legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      K_LOAD: begin
        word  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      K_STORE: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      K_BRANCH: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        legal = imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) && !imm[0];
      end
      K_JAL: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        legal = imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) && !imm[0];
      end
      K_JALR: begin
        // JALR has only one funct3 encoding, whatever the request carries.
        word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      K_CLZ: begin
        word  = {funct7, rs2, rs1, funct3, rd, OP_CLZ};
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: accepts field-level requests, packs them and
// writes the words to instruction memory at consecutive addresses.
// Handshakes: a request transfers on a rising edge where in_valid & in_ready;
// a memory write transfers on a rising edge where imem_we & imem_ready, and
// imem_addr/imem_wdata hold steady while imem_we is high and imem_ready low.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int          ADDR_W = 10,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output enc_state_e        dbg_state
);

  localparam logic [ADDR_W:0]   CAP_CNT  = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W+1:0] CAP_OCC  = (ADDR_W+2)'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE_ADR = ADDR_W'(BASE);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic [31:0]       pk_word;
  logic              pk_legal;
  logic              pend;
  logic              commit;
  logic              accept;
  logic [ADDR_W+1:0] occupancy;

  imm_packer u_packer (
    .kind   (in_kind),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .word   (pk_word),
    .legal  (pk_legal)
  );

  // Handshake: occupancy counts the pending word so the last free slot is
  // never double-booked; a stalled pending write blocks new input.
  always_comb begin
    pend      = (state_q == ST_PEND);
    commit    = pend && imem_ready;
    occupancy = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, pend};
    in_ready  = (occupancy < CAP_OCC) && (!pend || imem_ready) && !start;
    accept    = in_valid && in_ready;
  end

  // Next-state: start wins; otherwise commit advances addr/count and a legal
  // accept (re)loads the pending word, an illegal one only sets err.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (start) begin
      state_d = ST_EMPTY;
      addr_d  = BASE_ADR;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (commit) begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        state_d = ST_EMPTY;
      end
      if (accept) begin
        if (pk_legal) begin
          state_d = ST_PEND;
          wdata_d = pk_word;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State and registered outputs; reset abandons any pending write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      addr_q  <= BASE_ADR;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = (state_q == ST_PEND);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = (count_q == CAP_CNT);
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a small (4-word) memory so that the
// full/start behaviour is reachable; committed writes are checked against a
// queue of expected {addr, word} pairs.
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          imem_we;
  logic          imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;
  enc_state_e    dbg_state;

  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  exp_addr;
  int             n_cmp;
  int             n_mis;

  instr_encoder #(.ADDR_W(AW), .BASE(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a write commits on the edge following a negedge that sees
  // imem_we & imem_ready (inputs only change just after posedges).
  always @(negedge clk) begin
    if (rst_n && imem_we && imem_ready && !start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {30'd0, imem_addr, imem_wdata}, 64'hDEAD);
      end else begin
        chk("commit_addr_data", {30'd0, imem_addr, imem_wdata}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and wait (bounded) for acceptance; legal requests are
  // pushed to the scoreboard with the next expected address.
  task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic legal, input logic [31:0] word,
                      output int waited);
    logic acc;
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 20) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        if (legal) begin
          exp_q.push_back({exp_addr, word});
          exp_addr = exp_addr + 1'b1;
        end
      end
      tick();
      if (!acc) waited++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'(waited), 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = '0;
  endtask

  initial begin
    int w;
    n_cmp = 0; n_mis = 0;
    exp_addr = '0;
    start = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full_err", {62'd0, full, err}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // addi x1,x0,5
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, w);
    chk("addi_we", 64'(imem_we), 64'd1);
    chk("addi_wdata", 64'(imem_wdata), 64'h00500093);
    tick();
    chk("addi_count", 64'(count), 64'd1);
    chk("addi_we_drop", 64'(imem_we), 64'd0);

    // add x3,x1,x2 then sw x2,8(x1) back-to-back
    pulse_start();
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3, w);
    chk("b2b_wait0", 64'(w), 64'd0);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423, w);
    chk("b2b_wait1", 64'(w), 64'd0);
    tick();
    chk("b2b_count", 64'(count), 64'd2);

    // beq, jal, jalr (funct3 forced), clz -> fills the 4-word memory
    pulse_start();
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3, w);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h008000EF, w);
    send(3'd6, 5'd1, 5'd2, 5'd0, 3'd7, 7'd0, 32'd4, 1'b1, 32'h004100E7, w);
    send(3'd7, 5'd5, 5'd6, 5'd0, 3'd1, 7'h30, 32'd0, 1'b1, 32'h600312BB, w);
    chk("last_slot_ready", 64'(in_ready), 64'd0);
    chk("last_slot_full", 64'(full), 64'd0);
    tick();
    chk("full_count", 64'(count), 64'd4);
    chk("full_flag", 64'(full), 64'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_blocks", {62'd0, in_ready, imem_we}, 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("full_hold", 64'(full), 64'd1);
    pulse_start();
    chk("start_count", 64'(count), 64'd0);
    chk("start_full", 64'(full), 64'd0);
    chk("start_addr", 64'(imem_addr), 64'd0);

    // Range violations: consumed, nothing written, err sticky
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0, w);
    chk("bad_b_odd", {62'd0, imem_we, err}, 64'd1);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0, w);
    chk("bad_i_2048", {62'd0, imem_we, err}, 64'd1);
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0, 32'd0, w);
    send(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576, 1'b0, 32'd0, w);
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd2, 7'd0, 32'hFFFFF7FF, 1'b0, 32'd0, w);
    chk("bad_count", 64'(count), 64'd0);
    chk("bad_we", 64'(imem_we), 64'd0);
    // Boundary legal values, first one lands at the same address 0
    send(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00113, w);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 1'b1, 32'h80000093, w);
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 1'b1, 32'h7E000FE3, w);
    send(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 1'b1, 32'h8000006F, w);
    tick();
    chk("bound_count", 64'(count), 64'd4);
    chk("err_sticky", 64'(err), 64'd1);
    pulse_start();
    chk("start_err", 64'(err), 64'd0);

    // Memory stall: outputs hold, input blocked
    imem_ready = 1'b0;
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, w);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {imem_we, in_ready, 28'd0, imem_addr, imem_wdata},
          {1'b1, 1'b0, 28'd0, 2'd0, 32'h00500093});
      tick();
    end
    chk("stall_count", 64'(count), 64'd0);
    imem_ready = 1'b1;
    tick();
    chk("stall_commit", 64'(count), 64'd1);

    // Reset asserted mid-write
    imem_ready = 1'b0;
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h008000EF, w);
    chk("pend_before_rst", 64'(imem_we), 64'd1);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_addr = '0;
    #1;
    chk("rst_mid_we", 64'(imem_we), 64'd0);
    chk("rst_mid_regs", {27'd0, count, imem_addr, imem_wdata}, 64'd0);
    chk("rst_mid_flags", {62'd0, full, err}, 64'd0);
    tick();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    tick();
    chk("ready_after_rst2", 64'(in_ready), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: accepts field-level instruction requests (kind, registers, funct, signed immediate) over a valid/ready handshake. It packs each request into a 32-bit word whose opcode matches the core's control decoding (R, I-arith, LOAD, STORE, BRANCH, JAL, JALR, custom CLZ) and writes the word into instruction memory at consecutive word addresses. It sits on the program-load path ahead of the pipelined core; the core's decoder is the consumer of its output.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity 2**ADDR_W words
- BASE, 0, first word address written after reset or `start`
---
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: restart program at BASE, clear count and err
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_kind  in  3  0 R, 1 I-arith, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 CLZ
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  signed immediate, byte offset for BRANCH/JAL
- imem_we  out  1  write request, held until imem_ready
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words committed since reset/start
- full  out  1  count == 2**ADDR_W
- err  out  1  sticky: a request was rejected

## Operation
- Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, CLZ 0111011.
- Formats: R/CLZ = funct7|rs2|rs1|funct3|rd|op. I/LOAD/JALR = imm[11:0]|rs1|funct3|rd|op; JALR forces funct3=000. S = imm[11:5]|rs2|rs1|funct3|imm[4:0]|op. B = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op. J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Range check on the accepted request:
  - I/S: −2048..2047.
  - B: −4096..4094 and even.
  - J: −1048576..1048574 and even.
  - R/CLZ: in_imm ignored.
- Violation: request is consumed (handshake completes), no write is issued, count is unchanged, and err is set.
- States:
  - EMPTY: no pending write.
  - PEND: imem_we=1, holding addr/wdata.
  - Transitions: EMPTY→PEND on an accepted legal request. PEND→EMPTY on imem_ready with no new legal accept. PEND→PEND on imem_ready plus a legal accept in the same cycle (back-to-back).
- Address/count:
  - On each cycle with imem_we & imem_ready, imem_addr and count each increment by 1.
  - imem_addr wraps modulo 2**ADDR_W; it never wraps in practice because full blocks further input.
- in_ready = !full_next & (state==EMPTY | imem_ready) & !start, where full_next counts the pending word.
- start has priority over everything: the pending write is dropped (imem_we=0 next cycle), imem_addr=BASE, count=0, err=0, and in_valid is not accepted that cycle.

## Timing
- Reset (async, rst_n=0) values:
  - state EMPTY, imem_we=0, imem_addr=BASE, imem_wdata=0, count=0, full=0, err=0.
  - in_ready=1 from the first clock edge after release.
- Latency: accept at edge N → imem_we/addr/wdata valid after edge N, and the write commits at the first edge with imem_ready.
- Throughput: one word per cycle while imem_ready stays high.
- imem_addr/imem_wdata are stable while imem_we=1 and imem_ready=0.
- Full:
  - When 2**ADDR_W − 1 words are committed and one is pending, in_ready=0.
  - full asserts the cycle after the last commit.
  - Only start or reset clears it.
- Reset asserted mid-write: the write is abandoned immediately, and imem_we falls asynchronously.

## Structure
- Shared package instr_pkg: the 7-bit opcode constants (shared with the core decoder), the in_kind enum, and the immediate range limits.
- Sub-module imm_packer (combinational): kind + imm + fields → {word, legal}. The parent holds the handshake, PEND register, address counter and flags.

## Test plan
- addi x1,x0,5 (kind 1, f3 000, imm 5) → imem_wdata 0x00500093 at addr BASE; count 1.
- add x3,x1,x2 then sw x2,8(x1) back-to-back with imem_ready=1 → 0x002081B3 @0, 0x0020A423 @1 on consecutive cycles; in_ready never drops.
- beq x1,x2,−4 → 0xFE208EE3; jal x1,8 → 0x008000EF; jalr with in_funct3=3'b111 → funct3 field 000.
- Branch imm 3, then I imm 2048 → both consumed, no imem_we, err=1, count unchanged; next legal request writes at the same address.
- imem_ready held low 5 cycles → imem_we, addr, wdata stable and in_ready=0; commits on the cycle imem_ready rises.
- ADDR_W=2: after 4 commits full=1, in_ready=0. Then start → count 0, full 0, next write at BASE. Also rst_n pulsed mid-PEND → imem_we=0 immediately and all outputs at reset values.
